// File: rtl/branch_target_buffer_if.sv
// Lookup and update signal bundle for the branch target buffer.
// master drives lookups and resolved-branch updates; slave is the BTB itself.
interface branch_target_buffer_if;
  logic [15:0] lookup_pc;
  logic        pred_taken;
  logic [15:0] pred_next_pc;
  logic        update_en;
  logic [15:0] update_pc;
  logic [15:0] update_target;
  logic        update_taken;
  logic        update_is_jump;

  modport master (
    output lookup_pc, update_en, update_pc, update_target, update_taken, update_is_jump,
    input  pred_taken, pred_next_pc
  );

  modport slave (
    input  lookup_pc, update_en, update_pc, update_target, update_taken, update_is_jump,
    output pred_taken, pred_next_pc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_BYPASS_EN to forward a same-PC update into the same-cycle lookup.
module branch_target_buffer #(
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned IDX_BITS = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  branch_target_buffer_if.slave bus
);
  localparam int unsigned TagW = 16 - IDX_BITS;

  typedef enum logic [1:0] {CtrSnt = 2'b00, CtrWnt = 2'b01, CtrWt = 2'b10, CtrSt = 2'b11} ctr_e;

  logic            valid_q  [ENTRIES];
  logic            valid_d  [ENTRIES];
  logic [TagW-1:0] tag_q    [ENTRIES];
  logic [TagW-1:0] tag_d    [ENTRIES];
  logic [15:0]     target_q [ENTRIES];
  logic [15:0]     target_d [ENTRIES];
  ctr_e            ctr_q    [ENTRIES];
  ctr_e            ctr_d    [ENTRIES];
  logic            ready_q, ready_d;

  logic [IDX_BITS-1:0] upd_idx, lk_idx;
  logic [TagW-1:0]     upd_tag, lk_tag;
  logic                upd_fire, upd_hit;
  logic                lk_valid, lk_hit;
  logic [TagW-1:0]     lk_entry_tag;
  logic [15:0]         lk_target;
  ctr_e                lk_ctr;

  assign upd_idx = bus.update_pc[IDX_BITS-1:0];
  assign upd_tag = bus.update_pc[15:IDX_BITS];
  assign lk_idx  = bus.lookup_pc[IDX_BITS-1:0];
  assign lk_tag  = bus.lookup_pc[15:IDX_BITS];

  // ready_q stays low through the first edge after reset release, dropping any update on it.
  assign ready_d  = 1'b1;
  assign upd_fire = bus.update_en & ready_q & reset_n;
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (upd_fire) begin
      if (upd_hit) begin
        if (bus.update_is_jump) begin
          ctr_d[upd_idx] = CtrSt;
        end else if (bus.update_taken) begin
          if (ctr_q[upd_idx] != CtrSt) ctr_d[upd_idx] = ctr_e'(ctr_q[upd_idx] + 2'd1);
        end else begin
          if (ctr_q[upd_idx] != CtrSnt) ctr_d[upd_idx] = ctr_e'(ctr_q[upd_idx] - 2'd1);
        end
        if (bus.update_taken) target_d[upd_idx] = bus.update_target;
      end else if (bus.update_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = bus.update_target;
        ctr_d[upd_idx]    = bus.update_is_jump ? CtrSt : CtrWt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q <= 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CtrWnt;
      end
    end else begin
      ready_q <= ready_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BTB_BYPASS_EN
  logic fwd;
  assign fwd = upd_fire && (bus.update_pc == bus.lookup_pc);

  always_comb begin
    lk_valid     = fwd ? valid_d[lk_idx]  : valid_q[lk_idx];
    lk_entry_tag = fwd ? tag_d[lk_idx]    : tag_q[lk_idx];
    lk_target    = fwd ? target_d[lk_idx] : target_q[lk_idx];
    lk_ctr       = fwd ? ctr_d[lk_idx]    : ctr_q[lk_idx];
  end
`else
  always_comb begin
    lk_valid     = valid_q[lk_idx];
    lk_entry_tag = tag_q[lk_idx];
    lk_target    = target_q[lk_idx];
    lk_ctr       = ctr_q[lk_idx];
  end
`endif

  // Short-circuit on valid keeps unreset tag bits from leaking X into the outputs.
  assign lk_hit = reset_n && lk_valid && (lk_entry_tag == lk_tag);

  always_comb begin
    bus.pred_taken   = lk_hit & lk_ctr[1];
    bus.pred_next_pc = bus.pred_taken ? lk_target : bus.lookup_pc + 16'd1;
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table, corner
// sequences and randomized traffic against a behavioural table model.
module tb_branch_target_buffer;
  localparam int Entries = 16;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_target_buffer_if bif ();

  branch_target_buffer #(
    .ENTRIES  (16),
    .IDX_BITS (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: one record per slot, counter kept as a plain 0..3 integer.
  bit m_valid [Entries];
  int m_tag   [Entries];
  int m_tgt   [Entries];
  int m_ctr   [Entries];

  function automatic void model_reset();
    for (int i = 0; i < Entries; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endfunction

  function automatic void model_update(bit en, int pc, int tgt, bit taken, bit jump);
    int idx = pc % Entries;
    int tag = pc / Entries;
    if (!en) return;
    if (m_valid[idx] && m_tag[idx] == tag) begin
      if (jump)       m_ctr[idx] = 3;
      else if (taken) m_ctr[idx] = (m_ctr[idx] >= 3) ? 3 : m_ctr[idx] + 1;
      else            m_ctr[idx] = (m_ctr[idx] <= 0) ? 0 : m_ctr[idx] - 1;
      if (taken) m_tgt[idx] = tgt;
    end else if (taken) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_tgt[idx]   = tgt;
      m_ctr[idx]   = jump ? 3 : 2;
    end
  endfunction

  function automatic void model_predict(int pc, output bit t, output int n);
    int idx = pc % Entries;
    bit hit = m_valid[idx] && (m_tag[idx] == pc / Entries);
    t = hit && (m_ctr[idx] >= 2);
    n = t ? m_tgt[idx] : (pc + 1) % 65536;
  endfunction

  function automatic void model_expect(int lpc, bit en, int upc, int tgt, bit taken, bit jump,
                                       output bit t, output int n);
`ifdef BTB_BYPASS_EN
    if (en && upc == lpc) begin
      bit sv_valid [Entries];
      int sv_tag [Entries];
      int sv_tgt [Entries];
      int sv_ctr [Entries];
      sv_valid = m_valid; sv_tag = m_tag; sv_tgt = m_tgt; sv_ctr = m_ctr;
      model_update(en, upc, tgt, taken, jump);
      model_predict(lpc, t, n);
      m_valid = sv_valid; m_tag = sv_tag; m_tgt = sv_tgt; m_ctr = sv_ctr;
      return;
    end
`endif
    model_predict(lpc, t, n);
  endfunction

  task automatic check(input string name, input bit exp_t, input int exp_n);
    checks++;
    if (bif.pred_taken !== exp_t || bif.pred_next_pc !== 16'(exp_n)) begin
      errors++;
      $display("FAIL %s: got pred_taken=%b pred_next_pc=%h, want %b %h", name,
               bif.pred_taken, bif.pred_next_pc, exp_t, 16'(exp_n));
    end
  endtask

  // Drive at negedge, check pre-edge outputs, let the edge apply, advance the model.
  task automatic step(input logic [15:0] lpc, input bit en, input logic [15:0] upc,
                      input logic [15:0] tgt, input bit taken, input bit jump,
                      input bit exp_t, input int exp_n, input string name);
    @(negedge clk);
    bif.lookup_pc      = lpc;
    bif.update_en      = en;
    bif.update_pc      = upc;
    bif.update_target  = tgt;
    bif.update_taken   = taken;
    bif.update_is_jump = jump;
    #1 check(name, exp_t, exp_n);
    @(posedge clk);
    model_update(en, upc, tgt, taken, jump);
    #1 bif.update_en = 1'b0;
  endtask

  task automatic rstep(input logic [15:0] lpc, input bit en, input logic [15:0] upc,
                       input logic [15:0] tgt, input bit taken, input bit jump,
                       input string name);
    bit t;
    int n;
    model_expect(lpc, en, upc, tgt, taken, jump, t, n);
    step(lpc, en, upc, tgt, taken, jump, t, n, name);
  endtask

  function automatic logic [15:0] rand_pc();
    int r = $urandom_range(0, 19);
    if (r == 19) return 16'hFFFF;
    return 16'(($urandom_range(0, 3) << 4) | $urandom_range(0, 15));
  endfunction

  typedef struct {
    logic [15:0] lpc;
    bit          en;
    logic [15:0] upc;
    logic [15:0] tgt;
    bit          taken;
    bit          jump;
    bit          exp_t;
    logic [15:0] exp_n;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit   bt;
    int   bn;
    logic [15:0] lpc, upc;

    // lpc, en, upc, tgt, taken, jump, exp_taken, exp_next (expected before the edge)
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0011});
    vecs.push_back('{16'h0000, 1, 16'h0010, 16'h0040, 1, 0, 0, 16'h0001});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0040});
    vecs.push_back('{16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0001});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0011});
    vecs.push_back('{16'h0000, 1, 16'h0010, 16'h0000, 0, 0, 0, 16'h0001});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0011});
    for (int i = 0; i < 4; i++)
      vecs.push_back('{16'h0005, 1, 16'h0020, 16'h0080, 1, 0, 0, 16'h0006});
    vecs.push_back('{16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0080});
    vecs.push_back('{16'h0005, 1, 16'h0020, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0080});
    vecs.push_back('{16'h0005, 1, 16'h0020, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0021});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0011});
    vecs.push_back('{16'h0005, 1, 16'h0010, 16'h0040, 1, 0, 0, 16'h0006});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0040});
    vecs.push_back('{16'h0005, 1, 16'h0110, 16'h0200, 1, 0, 0, 16'h0006});
    vecs.push_back('{16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0011});
    vecs.push_back('{16'h0110, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0200});
    vecs.push_back('{16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000});
    vecs.push_back('{16'h0005, 1, 16'h0007, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0007, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0008});
    vecs.push_back('{16'h0005, 1, 16'h0008, 16'h0300, 1, 1, 0, 16'h0006});
    vecs.push_back('{16'h0005, 1, 16'h0008, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0008, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0300});
    vecs.push_back('{16'h0005, 1, 16'h0008, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0005, 1, 16'h0008, 16'h0000, 0, 0, 0, 16'h0006});
    vecs.push_back('{16'h0008, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0009});
    vecs.push_back('{16'h0005, 1, 16'h0008, 16'h0301, 0, 1, 0, 16'h0006});
    vecs.push_back('{16'h0008, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0300});
    vecs.push_back('{16'h0005, 0, 16'h0008, 16'h0999, 1, 0, 0, 16'h0006});
    vecs.push_back('{16'h0008, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0300});

    reset_n            = 1'b0;
    bif.lookup_pc      = 16'h0010;
    bif.update_en      = 1'b0;
    bif.update_pc      = 16'h0000;
    bif.update_target  = 16'h0000;
    bif.update_taken   = 1'b0;
    bif.update_is_jump = 1'b0;
    model_reset();
    #2 check("in_reset_lookup", 1'b0, 16'h0011);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vecs[i])
      step(vecs[i].lpc, vecs[i].en, vecs[i].upc, vecs[i].tgt, vecs[i].taken, vecs[i].jump,
           vecs[i].exp_t, vecs[i].exp_n, $sformatf("vec%0d", i));

    // Same-cycle update and lookup of one PC on a slot held by another tag.
`ifdef BTB_BYPASS_EN
    step(16'h0030, 1, 16'h0030, 16'h0050, 1, 0, 1, 16'h0050, "same_cycle_fwd");
`else
    step(16'h0030, 1, 16'h0030, 16'h0050, 1, 0, 0, 16'h0031, "same_cycle_nofwd");
`endif
    step(16'h0030, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0050, "after_same_cycle");

    for (int i = 0; i < 600; i++) begin
      lpc = rand_pc();
      upc = ($urandom_range(0, 3) == 0) ? lpc : rand_pc();
      rstep(lpc, ($urandom_range(0, 3) != 0), upc, 16'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), $sformatf("rand%0d", i));
    end

    // Mid-run reset: a known-taken entry must miss as soon as reset_n falls.
    rstep(16'h0005, 1, 16'h0040, 16'h0123, 1, 1, "pre_reset_alloc");
    model_predict(16'h0040, bt, bn);
    step(16'h0040, 0, 16'h0000, 16'h0000, 0, 0, bt, bn, "pre_reset_hit");
    @(negedge clk);
    reset_n            = 1'b0;
    bif.lookup_pc      = 16'h0040;
    bif.update_en      = 1'b1;
    bif.update_pc      = 16'h0040;
    bif.update_target  = 16'h0777;
    bif.update_taken   = 1'b1;
    bif.update_is_jump = 1'b1;
    #1 check("reset_async_miss", 1'b0, 16'h0041);
    @(posedge clk);
    #1 check("reset_update_ignored", 1'b0, 16'h0041);
    for (int i = 0; i < 4; i++) begin
      bif.lookup_pc = 16'((i << 4) | 4'h8);
      #1 check($sformatf("reset_miss%0d", i), 1'b0, ((i << 4) | 8) + 1);
    end
    @(negedge clk);
    bif.update_en = 1'b0;
    reset_n       = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    step(16'h0040, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0041, "post_reset_miss");
    rstep(16'h0005, 1, 16'h0040, 16'h0124, 1, 0, "post_reset_alloc");
    step(16'h0040, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h0124, "post_reset_hit");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
